// File: rtl/xgmii_rx_word_packer_pkg.sv
// Shared constants, FSM encoding and per-beat decode payload for the XGMII receive word packer.
package xgmii_rx_word_packer_pkg;

    localparam int unsigned XGMII_W       = 64;
    localparam int unsigned DATA_WIDTH    = 256;
    localparam int unsigned CTRL_WIDTH    = 32;
    localparam int unsigned LANES         = XGMII_W / 8;
    localparam int unsigned BEATS         = DATA_WIDTH / XGMII_W;
    localparam int unsigned BEAT_CNT_W    = $clog2(BEATS);
    localparam int unsigned SOF_W         = DATA_WIDTH / 32;
    localparam int unsigned COLS_PER_BEAT = LANES / 4;
    localparam int unsigned CTRL_OUT_W    = CTRL_WIDTH + SOF_W;
    localparam int unsigned FRAME_CNT_W   = 32;
    localparam int unsigned DROP_CNT_W    = 16;
    localparam int unsigned SOF_HI_LANE   = 4;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_TAIL  = 2'd2,
        ST_DROP  = 2'd3
    } state_e;

    typedef struct packed {
        logic sof_l0;
        logic sof_l4;
        logic has_term;
        logic sof_after_term;
    } beat_info_t;

endpackage

// File: rtl/xgmii_rx_word_packer_beat_decode.sv
// Combinational per-beat decode of XGMII start/terminate control characters.
module xgmii_rx_word_packer_beat_decode
    import xgmii_rx_word_packer_pkg::*;
(
    input  logic [XGMII_W-1:0] i_rxd,
    input  logic [LANES-1:0]   i_rxc,
    output beat_info_t         o_info
);

    logic [LANES-1:0] w_term;

    always_comb begin
        w_term = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_term[i] = i_rxc[i] && (i_rxd[8*i +: 8] == XGMII_TERM);
        end
    end

    // /S/ may only sit on lane 0 or lane 4, so "/S/ after /T/" means lane-4 start with a low-half terminate.
    always_comb begin
        o_info                = '0;
        o_info.sof_l0         = i_rxc[0] && (i_rxd[7:0] == XGMII_START);
        o_info.sof_l4         = i_rxc[SOF_HI_LANE] && (i_rxd[8*SOF_HI_LANE +: 8] == XGMII_START);
        o_info.has_term       = |w_term;
        o_info.sof_after_term = o_info.sof_l4 && (|w_term[SOF_HI_LANE-1:0]);
    end

endmodule

// File: rtl/xgmii_rx_word_packer.sv
// Packs four XGMII beats into one 256-bit pre-FIFO word with per-column SOF markers,
// dropping frames whose word completes against a full FIFO.
module xgmii_rx_word_packer
    import xgmii_rx_word_packer_pkg::*;
(
    input  logic                   x_clk,
    input  logic                   reset,
    input  logic                   rx_en,
    input  logic [XGMII_W-1:0]     xgmii_rxd,
    input  logic [LANES-1:0]       xgmii_rxc,
    input  logic                   fifo_full,
    input  logic                   cnt_clr,
    output logic                   x_we,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [CTRL_OUT_W-1:0]  ctrl_out,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [DROP_CNT_W-1:0]  drop_cnt,
    output logic                   in_frame
);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [BEAT_CNT_W-1:0]   r_beat_cnt;
    logic [DATA_WIDTH-1:0]   r_data_acc;
    logic [DATA_WIDTH-1:0]   w_data_acc;
    logic [CTRL_WIDTH-1:0]   r_ctrl_acc;
    logic [CTRL_WIDTH-1:0]   w_ctrl_acc;
    logic [SOF_W-1:0]        r_sof_acc;
    logic [SOF_W-1:0]        w_sof_acc;
    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic [CTRL_OUT_W-1:0]   r_ctrl_out;
    logic [FRAME_CNT_W-1:0]  r_frame_cnt;
    logic [DROP_CNT_W-1:0]   r_drop_cnt;
    logic                    r_in_frame;
    logic                    w_accept;
    logic                    w_complete;
    logic                    w_overflow;
    logic                    w_write;
    logic                    w_frame_inc;
    logic                    w_last;
    beat_info_t              w_info;

    xgmii_rx_word_packer_beat_decode u_decode (
        .i_rxd  (xgmii_rxd),
        .i_rxc  (xgmii_rxc),
        .o_info (w_info)
    );

    assign w_last = (r_beat_cnt == LAST_BEAT);

    always_ff @(posedge x_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, beat acceptance and frame/drop decisions; overflow overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_frame_inc = 1'b0;
        w_complete  = 1'b0;
        w_overflow  = 1'b0;
        w_write     = 1'b0;
        if (rx_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_info.sof_l0 || w_info.sof_l4) begin
                        w_accept    = 1'b1;
                        w_frame_inc = 1'b1;
                        w_state_nxt = ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    w_accept = 1'b1;
                    if (w_info.sof_after_term) begin
                        w_frame_inc = 1'b1;
                    end else if (w_info.has_term) begin
                        w_state_nxt = w_last ? ST_IDLE : ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    w_accept = 1'b1;
                    if (w_info.sof_l0 || w_info.sof_l4) begin
                        w_frame_inc = 1'b1;
                        w_state_nxt = ST_FRAME;
                    end else if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (w_info.has_term) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
            w_complete = w_accept && w_last;
            w_overflow = w_complete && fifo_full;
            w_write    = w_complete && !fifo_full;
            if (w_overflow) begin
                w_state_nxt = ST_DROP;
                w_frame_inc = 1'b0;
            end
        end
    end

    // Merge the current beat into its slot of the partial word.
    always_comb begin
        w_data_acc = r_data_acc;
        w_ctrl_acc = r_ctrl_acc;
        w_sof_acc  = (r_beat_cnt == '0) ? '0 : r_sof_acc;
        for (int i = 0; i < int'(BEATS); i++) begin
            if (r_beat_cnt == BEAT_CNT_W'(i)) begin
                w_data_acc[XGMII_W*i +: XGMII_W]  = xgmii_rxd;
                w_ctrl_acc[LANES*i +: LANES]      = xgmii_rxc;
                w_sof_acc[COLS_PER_BEAT*i]        = w_info.sof_l0;
                w_sof_acc[COLS_PER_BEAT*i + 1]    = w_info.sof_l4;
            end
        end
    end

    always_ff @(posedge x_clk or posedge reset) begin
        if (reset) begin
            r_beat_cnt <= '0;
            r_data_acc <= '0;
            r_ctrl_acc <= '0;
            r_sof_acc  <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
            r_data_acc <= w_data_acc;
            r_ctrl_acc <= w_ctrl_acc;
            r_sof_acc  <= w_sof_acc;
        end
    end

    always_ff @(posedge x_clk or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_data_out <= '0;
            r_ctrl_out <= '0;
            r_in_frame <= 1'b0;
        end else begin
            r_we       <= w_write;
            r_in_frame <= (w_state_nxt == ST_FRAME) || (w_state_nxt == ST_TAIL);
            if (w_write) begin
                r_data_out <= w_data_acc;
                r_ctrl_out <= {w_sof_acc, w_ctrl_acc};
            end
        end
    end

    // Clear wins over a same-cycle increment; drop count saturates.
    always_ff @(posedge x_clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else if (cnt_clr) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
            if (w_overflow && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    assign x_we      = r_we;
    assign data_out  = r_data_out;
    assign ctrl_out  = r_ctrl_out;
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign in_frame  = r_in_frame;

endmodule

// File: tb/tb_xgmii_rx_word_packer.sv
// Directed self-checking bench for the XGMII receive word packer.
module tb_xgmii_rx_word_packer;

    logic         x_clk = 1'b0;
    logic         reset;
    logic         rx_en;
    logic [63:0]  xgmii_rxd;
    logic [7:0]   xgmii_rxc;
    logic         fifo_full;
    logic         cnt_clr;
    logic         x_we;
    logic [255:0] data_out;
    logic [39:0]  ctrl_out;
    logic [31:0]  frame_cnt;
    logic [15:0]  drop_cnt;
    logic         in_frame;

    int n_tests = 0;
    int n_fail  = 0;
    int step    = 0;

    localparam logic [63:0] S0 = 64'hD5555555555555FB;
    localparam logic [63:0] S4 = 64'h555555FB07070707;
    localparam logic [63:0] TI = 64'h07070707070707FD;
    localparam logic [63:0] II = 64'h0707070707070707;
    localparam logic [63:0] TS = 64'h555555FB0707FDAB;

    xgmii_rx_word_packer dut (
        .x_clk     (x_clk),
        .reset     (reset),
        .rx_en     (rx_en),
        .xgmii_rxd (xgmii_rxd),
        .xgmii_rxc (xgmii_rxc),
        .fifo_full (fifo_full),
        .cnt_clr   (cnt_clr),
        .x_we      (x_we),
        .data_out  (data_out),
        .ctrl_out  (ctrl_out),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .in_frame  (in_frame)
    );

    always #5 x_clk = ~x_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] dat(input int n);
        return 64'hA5A5000000000000 | 64'(n);
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] c, input logic exp_we);
        rx_en     = 1'b1;
        xgmii_rxd = d;
        xgmii_rxc = c;
        @(posedge x_clk);
        #1;
        step++;
        check($sformatf("x_we_step%0d", step), 256'(x_we), 256'(exp_we));
        rx_en     = 1'b0;
        fifo_full = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic gap();
        rx_en     = 1'b0;
        xgmii_rxd = S0;
        xgmii_rxc = 8'h01;
        @(posedge x_clk);
        #1;
        step++;
        check($sformatf("x_we_gap%0d", step), 256'(x_we), 256'(1'b0));
    endtask

    initial begin
        reset     = 1'b1;
        rx_en     = 1'b0;
        xgmii_rxd = '0;
        xgmii_rxc = '0;
        fifo_full = 1'b0;
        cnt_clr   = 1'b0;
        #12;
        check("rst_we", 256'(x_we), 256'(0));
        check("rst_data", data_out, 256'(0));
        check("rst_ctrl", 256'(ctrl_out), 256'(0));
        check("rst_frame", 256'(frame_cnt), 256'(0));
        check("rst_drop", 256'(drop_cnt), 256'(0));
        check("rst_infr", 256'(in_frame), 256'(0));
        @(negedge x_clk);
        reset = 1'b0;
        @(posedge x_clk);
        #1;

        // 1: /S/ lane 0, 8 data beats, /T/ + idles -> three words
        beat(S0, 8'h01, 0);
        beat(dat(1), 8'h00, 0);
        beat(dat(2), 8'h00, 0);
        beat(dat(3), 8'h00, 1);
        check("t1_w0_data", data_out, {dat(3), dat(2), dat(1), S0});
        check("t1_w0_ctrl", 256'(ctrl_out), 256'(40'h01_00000001));
        beat(dat(4), 8'h00, 0);
        beat(dat(5), 8'h00, 0);
        beat(dat(6), 8'h00, 0);
        beat(dat(7), 8'h00, 1);
        check("t1_w1_data", data_out, {dat(7), dat(6), dat(5), dat(4)});
        beat(dat(8), 8'h00, 0);
        beat(TI, 8'hFF, 0);
        beat(II, 8'hFF, 0);
        check("t1_infr_tail", 256'(in_frame), 256'(1));
        beat(II, 8'hFF, 1);
        check("t1_w2_data", data_out, {II, II, TI, dat(8)});
        check("t1_w2_ctrl", 256'(ctrl_out), 256'(40'h00_FFFFFF00));
        check("t1_infr_end", 256'(in_frame), 256'(0));
        check("t1_frames", 256'(frame_cnt), 256'(1));
        beat(II, 8'hFF, 0);

        // 2: /S/ lane 4 with rx_en toggling
        beat(S4, 8'h1F, 0);
        gap();
        beat(dat(1), 8'h00, 0);
        gap();
        beat(dat(2), 8'h00, 0);
        gap();
        beat(dat(3), 8'h00, 1);
        gap();
        check("t2_w0_data", data_out, {dat(3), dat(2), dat(1), S4});
        check("t2_w0_ctrl", 256'(ctrl_out), 256'(40'h02_0000001F));
        beat(TI, 8'hFF, 0);
        beat(II, 8'hFF, 0);
        beat(II, 8'hFF, 0);
        beat(II, 8'hFF, 1);
        check("t2_w1_ctrl", 256'(ctrl_out), 256'(40'h00_FFFFFFFF));
        check("t2_frames", 256'(frame_cnt), 256'(2));

        // 3: /T/ lane 1 followed by /S/ lane 4 in one beat
        beat(S0, 8'h01, 0);
        beat(dat(1), 8'h00, 0);
        beat(TS, 8'h1E, 0);
        beat(dat(3), 8'h00, 1);
        check("t3_w0_data", data_out, {dat(3), TS, dat(1), S0});
        check("t3_w0_ctrl", 256'(ctrl_out), 256'(40'h21_001E0001));
        check("t3_frames", 256'(frame_cnt), 256'(4));
        check("t3_infr", 256'(in_frame), 256'(1));
        beat(TI, 8'hFF, 0);
        beat(II, 8'hFF, 0);
        beat(II, 8'hFF, 0);
        beat(II, 8'hFF, 1);
        check("t3_infr_end", 256'(in_frame), 256'(0));

        // 4: overflow on second word completion
        beat(S0, 8'h01, 0);
        beat(dat(11), 8'h00, 0);
        beat(dat(12), 8'h00, 0);
        beat(dat(13), 8'h00, 1);
        beat(dat(14), 8'h00, 0);
        beat(dat(15), 8'h00, 0);
        beat(dat(16), 8'h00, 0);
        fifo_full = 1'b1;
        beat(dat(17), 8'h00, 0);
        check("t4_drop", 256'(drop_cnt), 256'(1));
        check("t4_infr_drop", 256'(in_frame), 256'(0));
        check("t4_data_hold", data_out, {dat(13), dat(12), dat(11), S0});
        beat(dat(18), 8'h00, 0);
        beat(TS, 8'h1E, 0);
        check("t4_frames_drop", 256'(frame_cnt), 256'(5));
        check("t4_infr_idle", 256'(in_frame), 256'(0));
        beat(S0, 8'h01, 0);
        beat(dat(21), 8'h00, 0);
        beat(dat(22), 8'h00, 0);
        beat(dat(23), 8'h00, 1);
        check("t4_next_data", data_out, {dat(23), dat(22), dat(21), S0});
        check("t4_frames", 256'(frame_cnt), 256'(6));
        beat(TI, 8'hFF, 0);
        beat(II, 8'hFF, 0);
        beat(II, 8'hFF, 0);
        beat(II, 8'hFF, 1);

        // 5: async reset while x_we is high, then mid-word
        beat(S0, 8'h01, 0);
        beat(dat(1), 8'h00, 0);
        beat(dat(2), 8'h00, 0);
        beat(dat(3), 8'h00, 1);
        reset = 1'b1;
        #1;
        check("t5_we_async", 256'(x_we), 256'(0));
        check("t5_frame_rst", 256'(frame_cnt), 256'(0));
        check("t5_drop_rst", 256'(drop_cnt), 256'(0));
        check("t5_data_rst", data_out, 256'(0));
        @(negedge x_clk);
        reset = 1'b0;
        beat(S0, 8'h01, 0);
        beat(dat(1), 8'h00, 0);
        beat(dat(2), 8'h00, 0);
        reset = 1'b1;
        #1;
        check("t5_infr_rst", 256'(in_frame), 256'(0));
        check("t5_frame_rst2", 256'(frame_cnt), 256'(0));
        @(negedge x_clk);
        reset = 1'b0;
        beat(dat(9), 8'h00, 0);
        beat(S0, 8'h01, 0);
        beat(dat(31), 8'h00, 0);
        beat(dat(32), 8'h00, 0);
        beat(dat(33), 8'h00, 1);
        check("t5_new_data", data_out, {dat(33), dat(32), dat(31), S0});
        check("t5_frames", 256'(frame_cnt), 256'(1));
        beat(TI, 8'hFF, 0);
        beat(II, 8'hFF, 0);
        beat(II, 8'hFF, 0);
        beat(II, 8'hFF, 1);

        // 6: drop counter saturation and clear priority
        force dut.r_drop_cnt = 16'hFFFE;
        @(posedge x_clk);
        #1;
        release dut.r_drop_cnt;
        check("t6_preload", 256'(drop_cnt), 256'(16'hFFFE));
        beat(S0, 8'h01, 0);
        beat(dat(1), 8'h00, 0);
        beat(dat(2), 8'h00, 0);
        fifo_full = 1'b1;
        beat(dat(3), 8'h00, 0);
        check("t6_drop_max", 256'(drop_cnt), 256'(16'hFFFF));
        beat(TI, 8'hFF, 0);
        beat(S0, 8'h01, 0);
        beat(dat(1), 8'h00, 0);
        beat(dat(2), 8'h00, 0);
        fifo_full = 1'b1;
        beat(dat(3), 8'h00, 0);
        check("t6_drop_sat", 256'(drop_cnt), 256'(16'hFFFF));
        check("t6_frames", 256'(frame_cnt), 256'(3));
        beat(TI, 8'hFF, 0);
        cnt_clr = 1'b1;
        beat(S0, 8'h01, 0);
        check("t6_clr_frame", 256'(frame_cnt), 256'(0));
        check("t6_clr_drop", 256'(drop_cnt), 256'(0));
        check("t6_clr_infr", 256'(in_frame), 256'(1));
        beat(dat(1), 8'h00, 0);
        beat(dat(2), 8'h00, 0);
        fifo_full = 1'b1;
        cnt_clr   = 1'b1;
        beat(dat(3), 8'h00, 0);
        check("t6_clr_drop_inc", 256'(drop_cnt), 256'(0));
        check("t6_clr_frame2", 256'(frame_cnt), 256'(0));
        beat(TI, 8'hFF, 0);
        check("t6_infr_end", 256'(in_frame), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
